// File: rtl/uart_pkg.sv
// Shared definitions for the terminal UART: FSM states, frame shape and the
// baud divisor helper used by both transmit and (later) receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Rounded clock-per-bit divisor.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags; a push into a
// full FIFO is accepted when a pop happens on the same edge.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  assign pop  = rd_en && !empty_q;
  assign push = wr_en && (!full_q || pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = count_q;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding an 8N1 serialiser, with sticky overrun
// and an end-of-traffic pulse for the status register and IRQ.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 88_670_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    i_wr_data,
  input  logic                          i_wr_stb,
  input  logic                          i_enable,
  input  logic                          i_clr_overrun,
  output logic                          o_tx,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic                          o_done
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic             pop;
  logic             bit_end;
  logic             start_ok;
  logic [7:0]       fifo_rd_data;
  logic             fifo_full, fifo_empty;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (i_wr_stb),
    .wr_data (i_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign bit_end  = (cnt_q == CNT_LAST);
  assign start_ok = !fifo_empty && i_enable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q != STOP_LAST) begin
            bit_idx_d = bit_idx_q + 1'b1;
          end else if (start_ok) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            done_d  = fifo_empty;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // A dropped write outranks a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (i_wr_stb && fifo_full && !pop) overrun_d = 1'b1;
    else if (i_clr_overrun)            overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;
  assign o_full    = fifo_full;
  assign o_empty   = fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at DIV=10: stimulus queues expected bytes, a line
// monitor decodes each frame and compares it against the queue.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic       enable;
  logic       clr_ovr;
  logic       tx;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       busy;
  logic       overrun;
  logic       done;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .i_wr_data     (wr_data),
    .i_wr_stb      (wr_stb),
    .i_enable      (enable),
    .i_clr_overrun (clr_ovr),
    .o_tx          (tx),
    .o_full        (full),
    .o_empty       (empty),
    .o_level       (level),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_done        (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];

  int frames_seen = 0;
  int last_start = 0;
  int prev_start = 0;
  int done_count = 0;
  int last_done = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line monitor: samples every clock of a frame, then scores it.
  initial begin
    bit         mon_active;
    int         mon_cnt;
    logic [99:0] samp;
    logic [7:0] got;
    logic [7:0] b;
    logic [9:0] fexp;
    bit         shape_ok;
    mon_active = 1'b0;
    mon_cnt    = 0;
    samp       = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          prev_start = last_start;
          last_start = cyc;
        end
        if (mon_active) begin
          samp[mon_cnt] = tx;
          if (mon_cnt == 99) begin
            mon_active = 1'b0;
            frames_seen++;
            for (int k = 0; k < 8; k++) got[k] = samp[10*(k+1)+5];
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got byte 0x%02h, required no frame", got);
            end else begin
              b        = exp_q.pop_front();
              fexp     = {1'b1, b, 1'b0};
              shape_ok = 1'b1;
              for (int i = 0; i < 100; i++)
                if (samp[i] !== fexp[i/10]) shape_ok = 1'b0;
              check("frame_byte", int'(got), int'(b));
              check("frame_bit_timing", int'(shape_ok), 1);
            end
          end else begin
            mon_cnt++;
          end
        end
      end
      if (done === 1'b1) begin
        done_count++;
        last_done = cyc;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit will_send);
    wr_data = b;
    wr_stb  = 1'b1;
    @(negedge clk);
    wr_stb  = 1'b0;
    if (will_send) exp_q.push_back(b);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int t = 0;
    while (frames_seen < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, frames_seen, n);
  endtask

  task automatic wait_busy(input bit val, input int budget, input string name);
    int t = 0;
    while (busy !== val && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, int'(busy), int'(val));
  endtask

  initial begin
    int wr_cyc;
    int fbase;
    int dbase;
    rst_n   = 1'b0;
    wr_data = 8'h00;
    wr_stb  = 1'b0;
    enable  = 1'b0;
    clr_ovr = 1'b0;
    wait_cycles(3);

    check("rst_tx", int'(tx), 1);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Single byte
    enable = 1'b1;
    push(8'hA5, 1'b1);
    wr_cyc = cyc;
    check("single_level_after_write", int'(level), 1);
    wait_frames(1, 200, "single_frame_count");
    check("single_latency", last_start, wr_cyc + 1);
    wait_busy(1'b0, 20, "single_idle");
    @(negedge clk);
    check("single_done_count", done_count, 1);
    check("single_done_cycle", last_done, last_start + 100);
    check("single_tx_idle", int'(tx), 1);

    // Back-to-back
    dbase = done_count;
    push(8'h00, 1'b1);
    wr_cyc = cyc;
    check("b2b_level_first", int'(level), 1);
    push(8'hFF, 1'b1);
    check("b2b_level_second", int'(level), 1);
    wait_frames(3, 400, "b2b_frame_count");
    check("b2b_first_start", prev_start, wr_cyc + 1);
    check("b2b_contiguous", last_start - prev_start, 100);
    check("b2b_level_final", int'(level), 0);
    wait_busy(1'b0, 20, "b2b_idle");
    @(negedge clk);
    check("b2b_done_count", done_count, dbase + 1);
    check("b2b_total_length", last_done - prev_start, 200);

    // Overrun with enable low, then push at full on the first pop
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b1);
    check("ovr_full", int'(full), 1);
    check("ovr_level", int'(level), 8);
    check("ovr_not_yet", int'(overrun), 0);
    push(8'hEE, 1'b0);
    check("ovr_set", int'(overrun), 1);
    check("ovr_level_kept", int'(level), 8);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);

    enable = 1'b1;
    push(8'h3C, 1'b1);
    check("pushpop_level", int'(level), 8);
    check("pushpop_overrun", int'(overrun), 0);
    check("pushpop_busy", int'(busy), 1);
    fbase = frames_seen;
    wait_frames(fbase + 9, 1100, "pushpop_frame_count");
    wait_busy(1'b0, 20, "pushpop_idle");
    check("pushpop_empty", int'(empty), 1);

    // Enable drop mid-frame with two queued
    enable = 1'b0;
    push(8'h5A, 1'b1);
    push(8'hC3, 1'b0);
    check("endrop_level_queued", int'(level), 2);
    enable = 1'b1;
    wait_busy(1'b1, 5, "endrop_started");
    check("endrop_level_after_pop", int'(level), 1);
    wait_cycles(45);
    enable = 1'b0;
    dbase = done_count;
    fbase = frames_seen;
    wait_frames(fbase + 1, 200, "endrop_frame_count");
    wait_busy(1'b0, 20, "endrop_idle");
    @(negedge clk);
    check("endrop_level_left", int'(level), 1);
    check("endrop_no_done", done_count, dbase);
    wait_cycles(30);
    check("endrop_no_new_frame", frames_seen, fbase + 1);
    check("endrop_still_idle", int'(busy), 0);

    // Reset mid-frame
    enable = 1'b1;
    wait_busy(1'b1, 5, "rstmid_started");
    wait_cycles(30);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_tx", int'(tx), 1);
    check("rstmid_empty", int'(empty), 1);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_level", int'(level), 0);
    exp_q.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    fbase = frames_seen;
    wait_cycles(150);
    check("rstmid_nothing_sent", frames_seen, fbase);
    check("rstmid_tx_idle", int'(tx), 1);
    check("rstmid_still_idle", int'(busy), 0);

    check("all_expected_sent", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit half of the 6809 terminal UART. Sits directly downstream of `uart_interface`: it accepts bytes the CPU writes to the UART data register, buffers them in a small FIFO and serialises them 8N1 onto the FT2232 receive pin (`o_UART_RX` at top level). It runs entirely on the 88.67 MHz internal oscillator clock and reports FIFO and line status back to `uart_interface` for the status register and the IRQ.

## Interface
Parameters:
- `CLK_HZ`, 88_670_000: input clock frequency in Hz.
- `BAUD`, 115_200: line rate.
- `FIFO_DEPTH`, 8: number of FIFO entries; must be a power of two, at least 2.

Ports:
- `clk` input 1: internal oscillator clock.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `i_wr_data` input 8: byte to transmit.
- `i_wr_stb` input 1: one-cycle write strobe, generated from a 6809 write to the data register.
- `i_enable` input 1: transmitter enable, taken from a control register bit.
- `i_clr_overrun` input 1: one-cycle pulse that clears `o_overrun`.
- `o_tx` output 1: serial line; idles high.
- `o_full` output 1: FIFO full.
- `o_empty` output 1: FIFO empty.
- `o_level` output clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `o_busy` output 1: a frame is on the line, meaning state is not IDLE.
- `o_overrun` output 1: sticky flag; a write was dropped.
- `o_done` output 1: one-cycle pulse when the line goes idle with the FIFO empty.

## Operation
- Bit divisor is `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 770 for the defaults. Each bit lasts exactly DIV clocks. The bit counter is clog2(DIV) wide and wraps to 0 after reaching DIV-1.
- FIFO write:
  - A write happens on `i_wr_stb` when the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `o_overrun` is set.
  - If a set and `i_clr_overrun` occur in the same cycle, the set wins.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE to START: when the FIFO is not empty and `i_enable` is high. On that edge the FIFO pops, the shifter loads the byte, and `o_tx` goes to 0.
  - START to DATA: after DIV clocks. Bit index is 0 and `o_tx` is shifter[0].
  - DATA: data bits go out LSB first. After bit 7 (DIV clocks each), the FSM moves to STOP and `o_tx` goes to 1.
  - STOP, at the end of DIV clocks: if the FIFO is not empty and `i_enable` is high, pop and go to START with `o_tx` at 0, so there is no idle gap. Otherwise go to IDLE.
  - `o_done` pulses on the STOP-to-IDLE edge when the FIFO is empty.
- Deasserting `i_enable` mid-frame does not stop the current frame; it finishes normally. No new pop happens while `i_enable` is low.
- `o_tx` is a registered output with no combinational path from any input.
- Reset values:
  - `o_tx` is 1 and `o_empty` is 1.
  - `o_full`, `o_busy`, `o_overrun` and `o_done` are 0, and `o_level` is 0.
  - FSM is in IDLE and the FIFO pointers are 0.
  - A reset in the middle of a frame aborts it immediately (asynchronous) and discards the FIFO contents.

## Timing
- Write-to-line latency: a write on edge N into an empty FIFO with the FSM idle and enabled causes a pop on edge N+1, with `o_tx` falling at N+1.
- Frame length is 10×DIV clocks from the falling edge of the start bit to the end of the stop bit.
- Back-to-back frames are continuous; the next start bit begins on the clock immediately after the stop bit.
- Flags are registered and updated on the same edge as the write or pop:
  - `o_full`, `o_empty` and `o_level` reflect the count after that edge.
  - `o_overrun` asserts on the edge after the dropped strobe.
- Simultaneous push and pop leave `o_level` unchanged. At full, both operations are accepted.
- Pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - a constant function `baud_div(clk_hz, baud)`;
  - the frame constants: 8 data bits, 1 stop bit.
- One sub-module: `uart_sync_fifo` (parameters WIDTH and DEPTH; outputs full, empty and level). It is reusable later for the receive path.
- The top of this block contains the FSM, the baud counter, the shifter and the overrun logic.

## Test plan
All scenarios use CLK_HZ=1000 and BAUD=100, so DIV=10.
- Single byte: reset, then write 0xA5 with enable high. `o_tx` reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each for 10 clocks. `o_tx` falls 1 clock after the strobe, and `o_done` pulses at the end.
- Back-to-back: write 0x00 and 0xFF on consecutive cycles. This gives two contiguous frames lasting 200 clocks in total, with no high gap between stop and start. `o_level` goes 1, 1, 0 across the pops.
- Overrun: with enable low, write 9 bytes. `o_full` is 1 after 8, `o_level` is 8, `o_overrun` is 1, and the 9th byte is never sent. Pulse `i_clr_overrun` and check `o_overrun` is 0.
- Push and pop when full: fill the FIFO with 8 bytes, raise enable, and strobe in the same cycle as the first pop. The write is accepted, `o_overrun` stays 0 and `o_level` stays 8.
- Enable drop mid-frame: drop `i_enable` during DATA bit 3 with 2 bytes queued. The current frame completes, the FSM goes to IDLE, and `o_level` is 1.
- Reset mid-frame: assert `reset` during DATA. `o_tx` is 1 immediately, `o_empty` is 1 and `o_busy` is 0. After reset is released, nothing is transmitted.
